// File: rtl/a2d_pkg.sv
// rtl/a2d_pkg.sv - shared types and widths for the A2D channel scanner
package a2d_pkg;

  localparam int RES_W       = 12;
  localparam int CHNL_W      = 3;
  localparam int TIMEOUT_CYC = 4096;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_CMPLT,
    STORE,
    HOLD
  } a2d_state_e;

endpackage

// File: rtl/a2d_avg_accum.sv
// rtl/a2d_avg_accum.sv - per-channel sample accumulator and power-of-two averager
module a2d_avg_accum
  import a2d_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             add,
  input  logic [RES_W-1:0] smpl,
  output logic             last_smpl,
  output logic [RES_W-1:0] avg
);

  localparam int ACC_W = RES_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  // clr wins over add so an aborted final sample never lands in the sum
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (add) begin
      acc <= acc + ACC_W'(smpl);
      cnt <= cnt + 1'b1;
    end
  end

  assign last_smpl = (cnt == LAST_CNT);
  assign avg       = acc[ACC_W-1 -: RES_W];

endmodule

// File: rtl/a2d_chnl_scan.sv
// rtl/a2d_chnl_scan.sv - multi-channel A2D scan sequencer with averaged result registers
// Optional conversion timeout enabled by defining A2D_TIMEOUT_EN.
module a2d_chnl_scan
  import a2d_pkg::*;
#(
  parameter int NUM_CHNL    = 8,
  parameter int AVG_LOG2    = 2,
  parameter int SCAN_PERIOD = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              strt_cnv,
  output logic [CHNL_W-1:0] chnnl,
  input  logic              cnv_cmplt,
  input  logic [RES_W-1:0]  res,
  input  logic [CHNL_W-1:0] rd_chnl,
  output logic [RES_W-1:0]  rd_data,
  output logic [7:0]        vld,
  output logic              scan_done,
  output logic              busy,
  output logic              err
);

  localparam int PER_W = $clog2(SCAN_PERIOD + 1);
  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(SCAN_PERIOD - 1);
  localparam logic [CHNL_W-1:0] LAST_CHNL = CHNL_W'(NUM_CHNL - 1);

  a2d_state_e       state;
  logic             abort;
  logic [PER_W-1:0] per_cnt;
  logic [RES_W-1:0] res_q [NUM_CHNL];
  logic             acc_add;
  logic             acc_clr;
  logic             last_smpl;
  logic [RES_W-1:0] avg;
  logic             to_hit;

  assign acc_add = (state == WAIT_CMPLT) && cnv_cmplt;
  assign acc_clr = (state == STORE) || (acc_add && (abort || !en)) || to_hit;

  a2d_avg_accum #(
    .AVG_LOG2(AVG_LOG2)
  ) u_accum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .add      (acc_add),
    .smpl     (res),
    .last_smpl(last_smpl),
    .avg      (avg)
  );

`ifdef A2D_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);

  logic [TO_W-1:0] to_cnt;
  logic            err_q;

  assign to_hit = (state == WAIT_CMPLT) && !cnv_cmplt &&
                  (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign err    = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state == WAIT_CMPLT) && !cnv_cmplt)
        to_cnt <= to_cnt + 1'b1;
      else
        to_cnt <= '0;
      if (to_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  // Outputs are registered from the transition, so strt_cnv is high exactly
  // while in START and scan_done exactly in the last channel's STORE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      strt_cnv  <= 1'b0;
      chnnl     <= '0;
      vld       <= '0;
      scan_done <= 1'b0;
      busy      <= 1'b0;
      abort     <= 1'b0;
      per_cnt   <= '0;
      for (int i = 0; i < NUM_CHNL; i++)
        res_q[i] <= '0;
    end else begin
      strt_cnv  <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (en) begin
            state    <= START;
            strt_cnv <= 1'b1;
            busy     <= 1'b1;
            chnnl    <= '0;
            abort    <= 1'b0;
          end
        end
        START: begin
          state <= WAIT_CMPLT;
          if (!en)
            abort <= 1'b1;
        end
        WAIT_CMPLT: begin
          if (!en)
            abort <= 1'b1;
          if (cnv_cmplt) begin
            if (abort || !en) begin
              state <= IDLE;
              busy  <= 1'b0;
              abort <= 1'b0;
            end else if (last_smpl) begin
              state     <= STORE;
              scan_done <= (chnnl == LAST_CHNL);
            end else begin
              state    <= START;
              strt_cnv <= 1'b1;
            end
          end else if (to_hit) begin
            state <= IDLE;
            busy  <= 1'b0;
            abort <= 1'b0;
          end
        end
        STORE: begin
          for (int i = 0; i < NUM_CHNL; i++) begin
            if (chnnl == CHNL_W'(i)) begin
              res_q[i] <= avg;
              vld[i]   <= 1'b1;
            end
          end
          if (chnnl == LAST_CHNL) begin
            chnnl   <= '0;
            per_cnt <= '0;
            state   <= HOLD;
          end else begin
            chnnl    <= chnnl + 1'b1;
            state    <= START;
            strt_cnv <= 1'b1;
          end
        end
        HOLD: begin
          if (per_cnt == PER_LAST) begin
            if (en) begin
              state    <= START;
              strt_cnv <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            per_cnt <= per_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CHNL; i++)
      if (rd_chnl == CHNL_W'(i))
        rd_data = res_q[i];
  end

endmodule

// File: tb/tb_a2d_chnl_scan.sv
// tb/tb_a2d_chnl_scan.sv - self-checking bench for a2d_chnl_scan with A2D responder model
module tb_a2d_chnl_scan;

  localparam int NCH  = 8;
  localparam int AVGL = 2;
  localparam int SP   = 16;
  localparam int NSMP = 1 << AVGL;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [2:0]  rd_chnl;
  logic [11:0] rd_data;
  logic [7:0]  vld;
  logic        scan_done;
  logic        busy;
  logic        err;

  always #10 clk = ~clk;

  a2d_chnl_scan #(
    .NUM_CHNL(NCH),
    .AVG_LOG2(AVGL),
    .SCAN_PERIOD(SP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .strt_cnv (strt_cnv),
    .chnnl    (chnnl),
    .cnv_cmplt(cnv_cmplt),
    .res      (res),
    .rd_chnl  (rd_chnl),
    .rd_data  (rd_data),
    .vld      (vld),
    .scan_done(scan_done),
    .busy     (busy),
    .err      (err)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  rd;
    logic [11:0] exp;
  } rd_vec_t;
  rd_vec_t tv [16];

  // responder controls (written by main) and responder-owned state
  logic        resp_on   = 1'b0;
  int          resp_mode = 0;
  int          resp_lat  = 40;
  int          stray_cnt = 0;
  int          stray_done = 0;
  int          stab_err  = 0;
  int          log_ch [$];
  logic [11:0] log_v [$];

  // monitor-owned counters
  int cyc = 0, strt_n = 0, done_n = 0, done_cyc = 0, gap = 0;
  logic gap_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic rd_chk(input string name, input int ch, input logic [11:0] exp);
    rd_chnl = 3'(ch);
    #1;
    chk(name, rd_data, exp);
  endtask

  task automatic wait_done(input int base, input int budget, input string name);
    int k = 0;
    while (done_n == base && k < budget) begin
      tick();
      k++;
    end
    chk(name, done_n > base, 1);
  endtask

  // Reference: average of the samples the responder delivered to a channel since log index b
  function automatic logic [11:0] model_avg(input int b, input int ch);
    int sum = 0;
    for (int i = b; i < log_v.size(); i++)
      if (log_ch[i] == ch)
        sum += int'(log_v[i]);
    return 12'(sum / NSMP);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (strt_cnv) begin
        strt_n++;
        if (gap_pend) begin
          gap      = cyc - done_cyc;
          gap_pend = 1'b0;
        end
      end
      if (scan_done) begin
        done_n++;
        done_cyc = cyc;
        gap_pend = 1'b1;
      end
    end
  end

  initial begin
    int ch, run, prev, lat;
    logic [11:0] v;
    run = 0;
    prev = -1;
    cnv_cmplt = 1'b0;
    res = '0;
    forever begin
      @(posedge clk);
      #1;
      cnv_cmplt = 1'b0;
      if (stray_cnt != stray_done) begin
        stray_done++;
        res = 12'hFFF;
        cnv_cmplt = 1'b1;
      end else if (resp_on && strt_cnv) begin
        ch = int'(chnnl);
        if (ch != prev || run == NSMP)
          run = 0;
        prev = ch;
        case (resp_mode)
          0:       v = 12'h100 + 12'(ch);
          1:       v = 12'($urandom);
          default: v = 12'(10 + run + ch);
        endcase
        run++;
        lat = (resp_lat > 0) ? resp_lat : int'($urandom_range(1, 6));
        repeat (lat) begin
          @(posedge clk);
          #1;
        end
        if (int'(chnnl) != ch)
          stab_err++;
        res = v;
        cnv_cmplt = 1'b1;
        log_ch.push_back(ch);
        log_v.push_back(v);
      end
    end
  end

  initial begin
    int b_strt, b_done, b_log, k;
    for (int i = 0; i < NCH; i++) begin
      tv[i]     = '{3'(i), 12'h000};
      tv[i + 8] = '{3'(i), 12'h100 + 12'(i)};
    end
    rst_n = 1'b0;
    en = 1'b0;
    rd_chnl = '0;

    tick(3);
    rst_n = 1'b1;
    tick(1);
    chk("rst_strt", strt_cnv, 0);
    chk("rst_chnnl", chnnl, 0);
    chk("rst_vld", vld, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    for (int i = 0; i < 8; i++)
      rd_chk("rst_rd", int'(tv[i].rd), tv[i].exp);

    // reset in WAIT_CMPLT, then a stray completion one cycle after release
    en = 1'b1;
    tick(1);
    k = 0;
    while (!strt_cnv && k < 20) begin tick(); k++; end
    chk("first_strt", strt_cnv, 1);
    tick(3);
    chk("busy_wait", busy, 1);
    rst_n = 1'b0;
    en = 1'b0;
    tick(1);
    rst_n = 1'b1;
    stray_cnt++;
    tick(4);
    chk("rwait_strt", strt_cnv, 0);
    chk("rwait_chnnl", chnnl, 0);
    chk("rwait_vld", vld, 0);
    chk("rwait_busy", busy, 0);
    chk("rwait_done", scan_done, 0);
    chk("rwait_err", err, 0);

    // full deterministic scan, 40-cycle conversion latency
    b_strt = strt_n; b_done = done_n;
    resp_on = 1'b1; resp_mode = 0; resp_lat = 40;
    en = 1'b1;
    wait_done(b_done, 3000, "scan1_done");
    chk("scan1_strt", strt_n - b_strt, 32);
    chk("scan1_vld_store", vld, 8'h7F);
    rd_chk("store_old", 7, 12'h000);
    tick(1);
    chk("scan1_vld", vld, 8'hFF);
    chk("scan1_ndone", done_n - b_done, 1);
    for (int i = 8; i < 16; i++)
      rd_chk("scan1_rd", int'(tv[i].rd), tv[i].exp);

    // stray completion during HOLD must not disturb the period
    resp_mode = 1; resp_lat = 0;
    stray_cnt++;
    k = 0;
    while (strt_n == b_strt + 32 && k < 40) begin tick(); k++; end
    chk("hold_gap", gap, SP + 1);
    chk("hold_busy", busy, 1);
    rd_chk("hold_rd0", 0, 12'h100);

    // randomized scan against the reference model
    b_log = log_v.size(); b_done = done_n;
    wait_done(b_done, 2000, "scan2_done");
    tick(1);
    for (int c = 0; c < NCH; c++)
      rd_chk("rand_avg", c, model_avg(b_log, c));

    // scripted samples: channel c gets 10+c..13+c
    resp_mode = 2;
    tick(1);
    b_log = log_v.size(); b_done = done_n;
    wait_done(b_done, 2000, "scan3_done");
    tick(1);
    rd_chk("trunc_ch0", 0, 12'd11);
    rd_chk("trunc_ch7", 7, 12'd18);
    tick(1);
    for (int c = 0; c < NCH; c++)
      rd_chk("script_avg", c, model_avg(b_log, c));

    // abort during the 3rd sample of channel 5 after a fresh reset
    en = 1'b0;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    resp_mode = 0; resp_lat = 3;
    tick(2);
    b_strt = strt_n; b_log = log_v.size();
    en = 1'b1;
    k = 0;
    while (strt_n - b_strt < 23 && k < 500) begin tick(); k++; end
    chk("abort_reach", strt_n - b_strt, 23);
    en = 1'b0;
    k = 0;
    while (busy && k < 100) begin tick(); k++; end
    chk("abort_busy", busy, 0);
    chk("abort_vld", vld, 8'h1F);
    chk("abort_nsmp", log_v.size() - b_log, 23);
    rd_chk("abort_ch5", 5, 12'h000);
    rd_chk("abort_ch4", 4, 12'h104);
    tick(5);
    chk("abort_idle", strt_n - b_strt, 23);

    // restart after abort: no leftover accumulation
    b_done = done_n;
    en = 1'b1;
    wait_done(b_done, 2000, "scan4_done");
    en = 1'b0;
    tick(1);
    rd_chk("restart_ch5", 5, 12'h105);
    rd_chk("restart_ch0", 0, 12'h100);
    chk("restart_vld", vld, 8'hFF);
    k = 0;
    while (busy && k < 40) begin tick(); k++; end
    chk("hold_to_idle", busy, 0);

`ifdef A2D_TIMEOUT_EN
    resp_on = 1'b0;
    en = 1'b1;
    k = 0;
    while (!strt_cnv && k < 10) begin tick(); k++; end
    chk("to_strt", strt_cnv, 1);
    k = 0;
    while (!err && k < 5000) begin tick(); k++; end
    chk("to_cycles", k, 4097);
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    en = 1'b0;
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("to_err_clr", err, 0);
`endif

    chk("chnnl_stable", stab_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
